// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared FSM state encoding and requester ids for mem_port_arbiter
// Provides state_t (IDLE/BUSY) and the port ids PORT_IF / PORT_D.
package mem_arb_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of mem_port_arbiter
// master: arbiter view (takes requests and memory replies, drives acks and strobes)
// slave:  environment view (requesters plus the external memory)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;
    logic [ADDR_W-1:0] memory_addr;
    logic              memory_rden;
    logic              memory_wren;
    logic [DATA_W-1:0] memory_write_val;
    logic [DATA_W-1:0] memory_read_val;
    logic              memory_response;
    logic              busy;
    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, memory_read_val, memory_response,
        output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
        output memory_addr, memory_rden, memory_wren, memory_write_val, busy
    );
    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, memory_read_val, memory_response,
        input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
        input  memory_addr, memory_rden, memory_wren, memory_write_val, busy
    );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick
// i_elig: eligible vector indexed by port id; i_last: port granted last; o_gnt: one-hot grant
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_elig,
    input  logic       i_last,
    output logic [1:0] o_gnt
);
    assign o_gnt[PORT_IF] = i_elig[PORT_IF] & (~i_elig[PORT_D] | (i_last == PORT_D));
    assign o_gnt[PORT_D]  = i_elig[PORT_D] & (~i_elig[PORT_IF] | (i_last == PORT_IF));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters
// clk/reset: clock and asynchronous active-high reset
// bus: fetch req/ack, data req/ack, memory strobes/response and busy flag
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 8
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);
    state_t            r_state, w_state_n;
    logic              r_last, w_last_n, r_port, w_port_n;
    logic [TO_W-1:0]   r_cnt, w_cnt_n;
    logic [ADDR_W-1:0] r_addr, w_addr_n;
    logic              r_rden, w_rden_n, r_wren, w_wren_n;
    logic [DATA_W-1:0] r_wval, w_wval_n, r_rdata, w_rdata_n;
    logic              r_if_ack, w_if_ack_n, r_d_ack, w_d_ack_n, r_err, w_err_n;
    logic [1:0]        w_elig, w_gnt;
    logic              w_to, w_done;

    // A port whose ack is showing this cycle cannot be re-granted on the same edge.
    assign w_elig = {bus.d_req & ~r_d_ack, bus.if_req & ~r_if_ack};

    rr_arbiter2 u_rr (.i_elig(w_elig), .i_last(r_last), .o_gnt(w_gnt));

    // Counter holds the number of BUSY cycles already spent; abort on the last allowed one.
    assign w_to   = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_done = bus.memory_response | w_to;

    always_comb begin
        w_state_n  = r_state;
        w_last_n   = r_last;
        w_port_n   = r_port;
        w_cnt_n    = r_cnt;
        w_addr_n   = r_addr;
        w_rden_n   = r_rden;
        w_wren_n   = r_wren;
        w_wval_n   = r_wval;
        w_rdata_n  = '0;
        w_if_ack_n = 1'b0;
        w_d_ack_n  = 1'b0;
        w_err_n    = 1'b0;
        if (r_state == IDLE) begin
            if (|w_gnt) begin
                w_state_n = BUSY;
                w_port_n  = w_gnt[PORT_D];
                w_last_n  = w_gnt[PORT_D];
                w_cnt_n   = '0;
                w_addr_n  = w_gnt[PORT_D] ? bus.d_addr : bus.if_addr;
                w_wren_n  = w_gnt[PORT_D] & bus.d_we;
                w_rden_n  = ~(w_gnt[PORT_D] & bus.d_we);
                w_wval_n  = (w_gnt[PORT_D] & bus.d_we) ? bus.d_wdata : '0;
            end
        end else if (w_done) begin
            w_state_n  = IDLE;
            w_addr_n   = '0;
            w_rden_n   = 1'b0;
            w_wren_n   = 1'b0;
            w_wval_n   = '0;
            w_if_ack_n = (r_port == PORT_IF);
            w_d_ack_n  = (r_port == PORT_D);
            w_err_n    = ~bus.memory_response;
            w_rdata_n  = (bus.memory_response & r_rden) ? bus.memory_read_val : '0;
        end else begin
            w_cnt_n = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_last   <= PORT_D;
            r_port   <= PORT_IF;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_rden   <= 1'b0;
            r_wren   <= 1'b0;
            r_wval   <= '0;
            r_rdata  <= '0;
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_last   <= w_last_n;
            r_port   <= w_port_n;
            r_cnt    <= w_cnt_n;
            r_addr   <= w_addr_n;
            r_rden   <= w_rden_n;
            r_wren   <= w_wren_n;
            r_wval   <= w_wval_n;
            r_rdata  <= w_rdata_n;
            r_if_ack <= w_if_ack_n;
            r_d_ack  <= w_d_ack_n;
            r_err    <= w_err_n;
        end
    end

    assign bus.memory_addr      = r_addr;
    assign bus.memory_rden      = r_rden;
    assign bus.memory_wren      = r_wren;
    assign bus.memory_write_val = r_wval;
    assign bus.busy             = (r_state == BUSY);
    assign bus.if_ack           = r_if_ack;
    assign bus.d_ack            = r_d_ack;
    assign bus.if_rdata         = r_if_ack ? r_rdata : '0;
    assign bus.d_rdata          = r_d_ack ? r_rdata : '0;
    assign bus.if_err           = r_if_ack & r_err;
    assign bus.d_err            = r_d_ack & r_err;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port (memory_addr / rden / wren / read_val / write_val / response) between two requesters: instruction fetch (IF) and data load/store (D).
- Sits between the datapath's fetch and data-access logic and the external memory interface.
- Round-robin grant, one outstanding transaction, registered strobes, and a response timeout that returns an error instead of hanging the core.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 64, cycles in BUSY without memory_response before abort; 0 disables timeout.
- TO_W, 8, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level; held with if_addr stable until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  DATA_W  fetched word, valid while if_ack=1.
- if_err  out  1  fetch timed out, valid while if_ack=1.
- d_req  in  1  data request, level; held stable until d_ack.
- d_we  in  1  1=store, 0=load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle completion pulse for data.
- d_rdata  out  DATA_W  load data, valid while d_ack=1 (0 for stores).
- d_err  out  1  data access timed out, valid while d_ack=1.
- memory_addr  out  ADDR_W  to memory.
- memory_rden  out  1  read strobe.
- memory_wren  out  1  write strobe.
- memory_write_val  out  DATA_W  store data to memory.
- memory_read_val  in  DATA_W  read data from memory.
- memory_response  in  1  memory completion, one cycle.
- busy  out  1  1 while a transaction is outstanding.

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant=D, so IF wins the first tie; timeout counter 0.
- States:
  - IDLE: arbitration only.
  - BUSY: strobes asserted, waiting for memory_response or timeout.
- Eligibility in IDLE: a port is eligible if its req=1 and its ack is not high this cycle. Requesters must drop req in the ack cycle; this prevents a double grant.
- Arbitration:
  - One eligible port: grant it.
  - Both eligible: grant the port != last_grant.
  - On grant: last_grant updates, the request is latched, and the state moves to BUSY.
- BUSY outputs (registered from latched values):
  - memory_addr = latched address.
  - memory_rden = 1 for fetch or load.
  - memory_wren = 1 for store.
  - memory_write_val = d_wdata for store, 0 otherwise.
- Latency: req sampled at edge k; strobes high from cycle k+1. memory_response sampled at edge m; ack, rdata and err registered at edge m and visible in cycle m+1 (ack pulse). Strobes drop at the same edge m and the state returns to IDLE. Minimum turnaround: 3 cycles per transaction.
- memory_response is ignored in IDLE.
- Timeout: the counter clears on entering BUSY and increments each BUSY cycle. When it reaches TIMEOUT_CYCLES, the transaction aborts: strobes drop, ack pulses with err=1 and rdata=0, and the state returns to IDLE. memory_response arriving in that same cycle takes precedence (normal completion, err=0).
- Ack/rdata/err held 0 except in the pulse cycle.
- Requests changing while BUSY are ignored (only the latched copy is used). A req dropped before ack is a protocol violation; the transaction still completes and its ack is still issued.
- Reset mid-transaction: strobes drop immediately (asynchronous) and no ack is issued.
- busy = (state == BUSY).

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding: IDLE, BUSY.
  - port id constants: PORT_IF=0, PORT_D=1.
- Sub-module rr_arbiter2: combinational 2-way round-robin pick from {eligible vector, last_grant}, outputting the grant one-hot. The top level owns the FSM, latches, timeout counter and output registers.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0040, memory responds 2 cycles after rden with 0x8C01_0004 -> memory_rden=1 with addr 0x40 for 2 cycles, then if_ack=1 for one cycle with if_rdata=0x8C01_0004 and if_err=0.
- Single store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, immediate response -> memory_wren=1 with write_val=0xDEAD_BEEF, d_ack pulse, d_rdata=0, no rden seen.
- Simultaneous requests after reset, both held continuously with immediate responses -> grant order IF, D, IF, D; each ack exactly once per transaction; rden/wren never overlap.
- Timeout: TIMEOUT_CYCLES=4, d_req load with memory_response never asserted -> strobes high for exactly 4 cycles, then d_ack=1 with d_err=1 and d_rdata=0; a subsequent if_req is served normally.
- Spurious response in IDLE: memory_response=1 with no req -> no ack and no state change.
- Reset mid-BUSY: assert reset while rden=1 -> rden, busy and acks are 0 in the same cycle. After release, a held if_req is re-granted first.
